// File: rtl/cla_pkg.sv
// Shared definitions for the sequential carry-lookahead adder: FSM states and slice width.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/cla_seq_adder_if.sv
// Request/result bus of the sequential adder; the master drives operands and out_ready.
interface cla_seq_adder_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/fourbit_CLA.sv
// Combinational 4-bit carry-lookahead adder; also exposes the carry into bit 3 for overflow.
module fourbit_CLA
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c3_o,
    output logic               co_o
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic               c1;
    logic               c2;
    logic               c3;

    assign p = a_i ^ b_i;
    assign g = a_i & b_i;

    // Every carry is a flat sum of products of the slice inputs, with no ripple between bits.
    assign c1   = g[0] | (p[0] & c_i);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_i);
    assign co_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_i);

    assign s_o  = p ^ {c3, c2, c1, c_i};
    assign c3_o = c3;

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder/subtractor: one 4-bit CLA slice per RUN cycle, carry held in a flop.
module cla_seq_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    cla_seq_adder_if.slave bus
);

    localparam int NIB  = WIDTH / SLICE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              carry_q;
    logic              cout_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_c3;
    logic               sl_co;

    assign sl_a = a_q[{idx_q, 2'b00} +: SLICE_W];
    assign sl_b = b_q[{idx_q, 2'b00} +: SLICE_W];

    fourbit_CLA u_cla (
        .a_i  (sl_a),
        .b_i  (sl_b),
        .c_i  (carry_q),
        .s_o  (sl_s),
        .c3_o (sl_c3),
        .co_o (sl_co)
    );

    // Operands are captured only at accept; subtraction stores ~b so RUN is always an add.
    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.in_valid) begin
            a_q <= bus.a;
            b_q <= bus.sub ? ~bus.b : bus.b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        carry_q    <= bus.sub ? 1'b1 : bus.cin;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sum_q[{idx_q, 2'b00} +: SLICE_W] <= sl_s;
                    carry_q <= sl_co;
                    // idx parks on the last slice instead of wrapping.
                    if (idx_q == LAST) begin
                        cout_q      <= sl_co;
                        ovf_q       <= sl_c3 ^ sl_co;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Bench for cla_seq_adder: scenario tasks drive requests, a queue scoreboard checks each result.
module tb_cla_seq_adder;

    localparam int W   = 32;
    localparam int NIB = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cla_seq_adder_if #(.WIDTH(W)) bus ();

    cla_seq_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference: full-width add with overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [W-1:0] bo;
        logic         c;
        logic [W:0]   r;
        bo     = sub ? ~b : b;
        c      = sub ? 1'b1 : cin;
        r      = {1'b0, a} + {1'b0, bo} + {{W{1'b0}}, c};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (a[W-1] == bo[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each result handshake pops one expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL result: unexpected output sum=%h cout=%b ovf=%b", bus.sum, bus.cout, bus.ovf);
            end else begin
                e = sb.pop_front();
                if ({bus.sum, bus.cout, bus.ovf} !== e) begin
                    miscompares++;
                    $display("FAIL result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                             bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick;
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, n);
        end
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        sb.push_back(model(a, b, cin, sub));
        tick;
        bus.in_valid = 1'b0;
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.cin      = 1'($urandom_range(0, 1));
        bus.sub      = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_out(output int k);
        k = 0;
        while (!bus.out_valid && k < 100) begin
            tick;
            k++;
        end
    endtask

    task automatic release_out;
        bus.out_ready = 1'b1;
        tick;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        int k;
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h1111_1111;
        bus.cin      = 1'b0;
        bus.sub      = 1'b0;
        bus.out_ready = 1'b0;
        tick;
        tick;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {1'b1, 1'b0, {W{1'b0}}, 2'b00}) begin
            miscompares++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
        end
        bus.in_valid = 1'b0;
        #3 rst_n = 1'b1;
        send(32'h0000_00F0, 32'h0000_0010, 1'b0, 1'b0);
        wait_out(k);
        vectors++;
        if (k !== NIB) begin
            miscompares++;
            $display("FAIL first_after_reset_latency: got %0d cycles, required %0d", k, NIB);
        end
        release_out;
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         tc [4];
        logic         ts [4];
        int           k;
        ta = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7};
        tb = '{32'h0,         32'h0000_0001, 32'd7, 32'd5};
        tc = '{1'b1, 1'b0, 1'b1, 1'b0};
        ts = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send(ta[i], tb[i], tc[i], ts[i]);
            wait_out(k);
            vectors++;
            if (k !== NIB) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, required %0d", i, k, NIB);
            end
            release_out;
            vectors++;
            if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL directed_idle[%0d]: in_ready=%b out_valid=%b, required 1 0",
                         i, bus.in_ready, bus.out_valid);
            end
        end
    endtask

    task automatic test_stall;
        int   k;
        exp_t held;
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        wait_out(k);
        held = {bus.sum, bus.cout, bus.ovf};
        bus.in_valid = 1'b1;
        bus.a        = 32'hDEAD_BEEF;
        bus.b        = 32'h0BAD_F00D;
        bus.sub      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            vectors++;
            if ({bus.out_valid, bus.in_ready} !== 2'b10 || {bus.sum, bus.cout, bus.ovf} !== held) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b sum=%h, required 1 0 sum=%h",
                         i, bus.out_valid, bus.in_ready, bus.sum, held.sum);
            end
        end
        bus.in_valid = 1'b0;
        release_out;
        vectors++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10 || sb.size() != 0) begin
            miscompares++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b pending=%0d, required 1 0 0",
                     bus.in_ready, bus.out_valid, sb.size());
        end
    endtask

    task automatic test_reset_mid_run;
        int k;
        send(32'h1357_9BDF, 32'h2468_ACE0, 1'b1, 1'b0);
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.out_valid, bus.in_ready, bus.sum} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            miscompares++;
            $display("FAIL midrun_reset: out_valid=%b in_ready=%b sum=%h, required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.sum);
        end
        sb.delete();
        #2 rst_n = 1'b1;
        tick;
        send(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b1);
        wait_out(k);
        vectors++;
        if (k !== NIB) begin
            miscompares++;
            $display("FAIL after_abort_latency: got %0d cycles, required %0d", k, NIB);
        end
        release_out;
    endtask

    task automatic test_back_to_back;
        int k;
        for (int i = 0; i < 200; i++) begin
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_out(k);
            vectors++;
            if (k !== NIB) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d]: got %0d cycles, required %0d", i, k, NIB);
            end
            repeat ($urandom_range(0, 3)) tick;
            release_out;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        test_reset;
        test_directed;
        test_stall;
        test_reset_mid_run;
        test_back_to_back;
        tick;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant NIB = WIDTH/4 SHALL be the number of 4-bit slices per operation.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 a, b  input  WIDTH  operands, sampled at accept.
REQ-008 cin  input  1  carry-in, sampled at accept; ignored when sub=1.
REQ-009 sub  input  1  0 = a+b+cin; 1 = a-b, i.e. a+~b+1; sampled at accept.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of the MSB slice.
REQ-014 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept occurs on a clock edge with IDLE and in_valid=1: latch a, b (inverted if sub=1), carry = (sub ? 1 : cin), slice index = 0, clear sum, go to RUN.
REQ-018 In RUN, each cycle SHALL feed slice[idx] of the latched a and b plus the carry register into one 4-bit CLA.
REQ-019 In the same RUN cycle, the block SHALL write the 4-bit result into sum[4*idx+3:4*idx], load the carry register from the slice carry-out, and increment idx.
REQ-020 When idx = NIB-1 in RUN, the block SHALL go to DONE, set cout, and set ovf per REQ-014 using the MSB slice's bit-3 carry-in and carry-out.
REQ-021 Latency SHALL be exactly NIB cycles in RUN, with out_valid first high on the edge NIB cycles after accept (8 for WIDTH=32).
REQ-022 In DONE, sum, cout and ovf SHALL stay stable until out_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-023 Back-to-back operations SHALL have no same-cycle bypass: the earliest next accept is the cycle after the DONE handshake.
REQ-024 in_valid during RUN or DONE SHALL be ignored, with no side effects.
REQ-025 a, b, cin and sub changing after accept SHALL not affect the in-flight operation.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH; in subtract mode cout=1 SHALL mean no borrow (a >= b unsigned).
REQ-027 The idx counter SHALL be ceil(log2(NIB)) bits and never wrap within one operation.

Reset
REQ-028 rst_n low SHALL, asynchronously and in any state including mid-RUN, force the FSM to IDLE and abort any operation with no partial result presented.
REQ-029 Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, idx=0, carry=0.
REQ-030 On the first edge after rst_n deasserts, the block SHALL be able to accept a request.

Structure
REQ-031 The FSM state enum (IDLE, RUN, DONE) and the slice width constant 4 SHALL live in a shared package, cla_pkg.
REQ-032 The block SHALL instantiate exactly one 4-bit adder sub-module, the team's existing fourbit_CLA, and SHALL contain no other adder logic.
REQ-033 sum, cout, ovf, the carry register and the operand registers SHALL be flops; the datapath SHALL have no combinational path from in_* to out_*.

Verification
REQ-034 WIDTH=32, a=0xFFFFFFFF, b=0, cin=1, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid high 8 cycles after accept.
REQ-035 a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-036 a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
REQ-037 Hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second accept; out_ready=1 -> IDLE next cycle.
REQ-038 Assert rst_n=0 at RUN idx=3 -> out_valid=0, in_ready=1 immediately; a fresh request afterwards completes correctly in 8 cycles.
REQ-039 200 random back-to-back requests with random out_ready stalls -> every result equals the reference model (a+b+cin or a-b).
